// File: rtl/if_fetch_if.sv
// Instruction-memory channel between the fetch stage (master) and memory (slave).
// One request outstanding at a time; mem_addr holds from mem_req until mem_ack.
interface if_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding memory requester feeding a 2-entry
// {pc, instr} prefetch FIFO, with branch redirect and discard of stale responses.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  if_fetch_if.master  mem,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        stallreq_if
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(2);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  state_t          r_state, w_state_nxt;
  entry_t          r_fifo [2];
  logic            r_rd_ptr, w_rd_ptr_nxt;
  logic            w_wr_idx;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [XLEN-1:0] r_req_addr, w_req_addr_nxt;
  logic            r_drop, w_drop_nxt;
  logic            w_ack, w_push, w_pop;
  logic [XLEN-1:0] w_target;
  entry_t          w_head;
  logic            w_unused;

  // Only the fetch-stage stall bit matters; redirect targets are word aligned.
  assign w_unused = ^{stall[5:1], branch_target[1:0]};
  assign w_target = {branch_target[XLEN-1:2], 2'b00};

  // FIFO occupancy: a redirect flushes everything and wins over pop and push.
  always_comb begin
    w_ack        = (r_state == S_REQ) && mem.mem_ack;
    w_pop        = (r_count != '0) && !stall[0] && !branch_flag;
    w_push       = w_ack && !r_drop && !branch_flag;
    w_wr_idx     = r_rd_ptr ^ r_count[0];
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    if (branch_flag) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      w_rd_ptr_nxt = r_rd_ptr ^ w_pop;
    end
  end

  // Request FSM next-state and address bookkeeping.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_drop_nxt     = r_drop;
    case (r_state)
      S_IDLE: begin
        if (branch_flag) begin
          w_state_nxt    = S_REQ;
          w_req_addr_nxt = w_target;
          w_fetch_pc_nxt = w_target + PC_STEP;
        end else if (r_count < FULL) begin
          w_state_nxt    = S_REQ;
          w_req_addr_nxt = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
        end
      end
      S_REQ: begin
        if (branch_flag) begin
          if (mem.mem_ack) begin
            // Response in flight with the redirect is stale; go straight to the target.
            w_drop_nxt     = 1'b0;
            w_req_addr_nxt = w_target;
            w_fetch_pc_nxt = w_target + PC_STEP;
          end else begin
            // Keep the bus request stable; its data is thrown away on arrival.
            w_drop_nxt     = 1'b1;
            w_fetch_pc_nxt = w_target;
          end
        end else if (mem.mem_ack) begin
          if (r_drop) begin
            w_drop_nxt     = 1'b0;
            w_req_addr_nxt = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          end else if (w_count_nxt < FULL) begin
            w_req_addr_nxt = r_fetch_pc;
            w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= 1'b0;
      r_drop     <= 1'b0;
      r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_drop     <= w_drop_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Storage needs no reset: r_count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[w_wr_idx] <= '{pc: r_req_addr, instr: mem.mem_rdata};
    end
  end

  assign w_head       = r_fifo[r_rd_ptr];
  assign mem.mem_req  = (r_state == S_REQ);
  assign mem.mem_addr = r_req_addr;
  assign if_pc        = (r_count != '0) ? w_head.pc    : '0;
  assign if_instr     = (r_count != '0) ? w_head.instr : '0;
  assign stallreq_if  = (r_count == '0);

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: expected {pc, instr} pairs are queued as the
// program flow is set up and compared whenever the decode side consumes one.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stallreq_if;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .mem           (bus),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .stallreq_if   (stallreq_if)
  );

  always #5 clk = ~clk;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          mem_lat;
  bit          mem_en;
  logic        man_ack;
  logic [31:0] man_rdata;
  bit          busy = 1'b0;
  int          wait_cnt = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h1111_1111 * ((a >> 2) + 32'd1);
  endfunction

  task automatic push_exp(input logic [31:0] pc);
    sb.push_back('{pc: pc, instr: mem_data(pc)});
  endtask

  // Memory model: acks each request after mem_lat waiting cycles (0 = same cycle).
  always @(negedge clk) begin
    if (!mem_en) begin
      bus.mem_ack   = man_ack;
      bus.mem_rdata = man_rdata;
      busy          = 1'b0;
    end else if (bus.mem_req === 1'b1) begin
      if (!busy) begin
        busy     = 1'b1;
        wait_cnt = 0;
      end
      if (wait_cnt >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_data(bus.mem_addr);
        busy          = 1'b0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      busy          = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stall = '0; branch_flag = 1'b0; mem_en = 1'b1; mem_lat = 0; man_ack = 1'b0;
    @(negedge clk);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b required 0", bus.mem_req); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_if_pc: got %h required 0", if_pc); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_if_instr: got %h required 0", if_instr); end
    checks++; if (stallreq_if !== 1'b1) begin errors++; $display("FAIL rst_stallreq: got %b required 1", stallreq_if); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
      errors++; $display("FAIL rst_first_req: got req=%b addr=%h required req=1 addr=%h", bus.mem_req, bus.mem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    exp_t e;
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(RESET_PC + 32'(4 * i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'(4 * c)) begin
        errors++; $display("FAIL seq_addr: got req=%b addr=%h required req=1 addr=%h", bus.mem_req, bus.mem_addr, 32'(4 * c));
      end
      checks++; if (stallreq_if !== (c == 0)) begin
        errors++; $display("FAIL seq_stallreq: cycle %0d got %b required %b", c, stallreq_if, (c == 0));
      end
      if (stallreq_if === 1'b0) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL seq_pop: unexpected pc=%h", if_pc); end
        else begin
          e = sb.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            errors++; $display("FAIL seq_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    do_reset();
    stall = 6'b000001;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b required 0", bus.mem_req); end
      checks++; if (if_pc !== 32'h0 || if_instr !== 32'h1111_1111) begin
        errors++; $display("FAIL stall_head: got pc=%h instr=%h required pc=0 instr=11111111", if_pc, if_instr);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      stall = '0;
      if (c == 1) begin
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL stall_rel_req: got %b required 0", bus.mem_req); end
      end
      checks++;
      if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL stall_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
      else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++; $display("FAIL stall_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8 || stallreq_if !== 1'b1) begin
      errors++; $display("FAIL stall_fetch8: got req=%b addr=%h stallreq=%b required 1/00000008/1", bus.mem_req, bus.mem_addr, stallreq_if);
    end
    @(negedge clk);
    checks++;
    if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL stall_pop8: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        errors++; $display("FAIL stall_pop8: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_branch_wait();
    exp_t e;
    bit   got;
    do_reset();
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h100);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL bw_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
      else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++; $display("FAIL bw_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
        end
      end
      if (c == 0) begin #1 mem_lat = 3; end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      branch_flag = (c == 0); branch_target = 32'h103;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h8) begin
        errors++; $display("FAIL bw_hold: got req=%b addr=%h required req=1 addr=00000008", bus.mem_req, bus.mem_addr);
      end
    end
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
      errors++; $display("FAIL bw_target: got req=%b addr=%h required req=1 addr=00000100", bus.mem_req, bus.mem_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (stallreq_if === 1'b0) got = 1'b1;
      else begin
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
          errors++; $display("FAIL bw_bubble: got pc=%h instr=%h required 0/0", if_pc, if_instr);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL bw_timeout: stallreq_if=%b required 0", stallreq_if); end
    else if (sb.size() == 0) begin errors++; $display("FAIL bw_pop: unexpected pc=%h", if_pc); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        errors++; $display("FAIL bw_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
      end
    end
  endtask

  task automatic test_branch_ack_pop();
    exp_t e;
    do_reset();
    push_exp(32'h200); push_exp(32'h204);
    @(negedge clk);
    @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'h200;
    checks++; if (if_instr !== 32'h1111_1111) begin errors++; $display("FAIL bap_head: got %h required 11111111", if_instr); end
    @(negedge clk);
    branch_flag = 1'b0;
    checks++; if (stallreq_if !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL bap_flush: got stallreq=%b pc=%h instr=%h required 1/0/0", stallreq_if, if_pc, if_instr);
    end
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      errors++; $display("FAIL bap_target: got req=%b addr=%h required req=1 addr=00000200", bus.mem_req, bus.mem_addr);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL bap_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
      else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++; $display("FAIL bap_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_branch_idle();
    exp_t e;
    do_reset();
    stall = 6'b000001;
    push_exp(32'h3FC); push_exp(32'h400);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'h3FF;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL bi_idle: got req=%b required 0", bus.mem_req); end
    @(negedge clk);
    branch_flag = 1'b0; stall = '0;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3FC || stallreq_if !== 1'b1) begin
      errors++; $display("FAIL bi_target: got req=%b addr=%h stallreq=%b required 1/000003fc/1", bus.mem_req, bus.mem_addr, stallreq_if);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL bi_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
      else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++; $display("FAIL bi_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t        e;
    logic [31:0] wa [4];
    wa = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(wa[i]);
    @(negedge clk);
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFB;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      branch_flag = 1'b0;
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== wa[c]) begin
        errors++; $display("FAIL wrap_addr: got req=%b addr=%h required req=1 addr=%h", bus.mem_req, bus.mem_addr, wa[c]);
      end
      if (c > 0) begin
        checks++;
        if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL wrap_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
        else begin
          e = sb.pop_front();
          if (if_pc !== e.pc || if_instr !== e.instr) begin
            errors++; $display("FAIL wrap_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    mem_en = 1'b0; man_ack = 1'b0; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC) begin
      errors++; $display("FAIL rm_pending: got req=%b addr=%h required req=1 addr=%h", bus.mem_req, bus.mem_addr, RESET_PC);
    end
    rst = 1'b0;
    @(posedge clk); #1 man_ack = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0 || stallreq_if !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
      errors++; $display("FAIL rm_reset: got req=%b stallreq=%b pc=%h instr=%h required 0/1/0/0", bus.mem_req, stallreq_if, if_pc, if_instr);
    end
    rst = 1'b1;
    push_exp(RESET_PC);
    @(posedge clk); #1 mem_en = 1'b1;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== RESET_PC || stallreq_if !== 1'b1) begin
      errors++; $display("FAIL rm_restart: got req=%b addr=%h stallreq=%b required 1/%h/1", bus.mem_req, bus.mem_addr, stallreq_if, RESET_PC);
    end
    @(negedge clk);
    checks++;
    if (stallreq_if !== 1'b0 || sb.size() == 0) begin errors++; $display("FAIL rm_pop: stallreq_if=%b queued=%0d", stallreq_if, sb.size()); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        errors++; $display("FAIL rm_pop: got pc=%h instr=%h required pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
      end
    end
  endtask

  initial begin
    rst = 1'b0; stall = '0; branch_flag = 1'b0; branch_target = '0;
    mem_en = 1'b1; mem_lat = 0; man_ack = 1'b0; man_rdata = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_ack_pop();
    test_branch_idle();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
